prog_load_ctrl: RTL and testbench

//  Boot/program-load sequencer for cpu_core.
//  - Holds the core in reset.
//  - Receives a framed byte stream over a valid/ready link and assembles 16-bit instruction words.
//  - Writes the words into the 64x16 instruction memory, checks an XOR checksum.
//  - Releases the core to run from address 0 when the checksum matches.

---
 rtl/prog_load_ctrl_pkg.sv | 32 +++
 rtl/prog_word_asm.sv | 37 +++
 rtl/prog_load_ctrl.sv | 147 ++++++++++++++
 tb/tb_prog_load_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_load_ctrl_pkg.sv
// Shared state encoding and frame constants for the program loader.
// Also used by other loader and debug blocks.
package prog_load_ctrl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HDR     = 3'd1;
    localparam logic [2:0] ST_DHI     = 3'd2;
    localparam logic [2:0] ST_DLO     = 3'd3;
    localparam logic [2:0] ST_CSUM    = 3'd4;
    localparam logic [2:0] ST_RELEASE = 3'd5;
    localparam logic [2:0] ST_RUN     = 3'd6;
    localparam logic [2:0] ST_ERR     = 3'd7;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        HDR     = ST_HDR,
        DHI     = ST_DHI,
        DLO     = ST_DLO,
        CSUM    = ST_CSUM,
        RELEASE = ST_RELEASE,
        RUN     = ST_RUN,
        ERR     = ST_ERR
    } state_t;

    localparam int BYTE_W     = 8;
    localparam int WORD_W     = 16;
    localparam int DEF_ADDR_W = 6;

    // A zero header byte means a full-memory frame.
    localparam logic [BYTE_W-1:0] HDR_FULL = 8'h00;

endpackage

// File: rtl/prog_word_asm.sv
// Hi/lo byte assembly into instruction words plus running XOR checksum.
// The word write strobe is registered: one pulse after each lo byte.
module prog_word_asm
    import prog_load_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] data,
    input  logic              hdr_acc,
    input  logic              hi_acc,
    input  logic              lo_acc,
    output logic              we,
    output logic [WORD_W-1:0] word,
    output logic [BYTE_W-1:0] csum
);

    logic [BYTE_W-1:0] hi;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi   <= '0;
            we   <= 1'b0;
            word <= '0;
            csum <= '0;
        end else begin
            we <= lo_acc;
            if (hi_acc) hi <= data;
            if (lo_acc) word <= {hi, data};
            if (hdr_acc) begin
                csum <= data;
            end else if (hi_acc || lo_acc) begin
                csum <= csum ^ data;
            end
        end
    end

endmodule

// File: rtl/prog_load_ctrl.sv
// Boot sequencer: holds cpu_core in reset, loads a framed byte stream into
// instruction memory, verifies the checksum and then releases the core.
module prog_load_ctrl
    import prog_load_ctrl_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RST_HOLD = 4,
    parameter int AUTOLOAD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int              CAP     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CAP_W   = (ADDR_W+1)'(CAP);
    localparam logic [ADDR_W:0] WL_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
    localparam logic [3:0]      HOLD_LD = 4'(RST_HOLD - 1);

    state_t            state;
    state_t            state_nx;
    logic              acc;
    logic              hdr_acc;
    logic              hi_acc;
    logic              lo_acc;
    logic              hdr_bad;
    logic              last_word;
    logic              boot;
    logic [ADDR_W:0]   n_words;
    logic [3:0]        hold_cnt;
    logic [BYTE_W-1:0] csum;

    assign acc       = rx_valid && rx_ready;
    assign hdr_acc   = acc && (state == HDR);
    assign hi_acc    = acc && (state == DHI);
    assign lo_acc    = acc && (state == DLO);
    assign hdr_bad   = int'(rx_data) > CAP;
    assign last_word = (words_loaded + WL_ONE) == n_words;

    prog_word_asm u_asm (
        .clk     (clk),
        .rst     (rst),
        .data    (rx_data),
        .hdr_acc (hdr_acc),
        .hi_acc  (hi_acc),
        .lo_acc  (lo_acc),
        .we      (imem_we),
        .word    (imem_wdata),
        .csum    (csum)
    );

    always_comb begin
        state_nx = state;
        rx_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_req || (AUTOLOAD != 0 && boot)) state_nx = HDR;
            end
            HDR: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (acc) state_nx = hdr_bad ? ERR : DHI;
            end
            DHI: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (acc) state_nx = DLO;
            end
            DLO: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (acc) state_nx = last_word ? CSUM : DHI;
            end
            CSUM: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (acc) state_nx = (rx_data == csum) ? RELEASE : ERR;
            end
            RELEASE: begin
                busy = 1'b1;
                if (hold_cnt == 4'd0) state_nx = RUN;
            end
            RUN: begin
                done = 1'b1;
                if (load_req) state_nx = HDR;
            end
            ERR: begin
                err = 1'b1;
                if (load_req) state_nx = HDR;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            boot     <= 1'b1;
            core_rst <= 1'b1;
            hold_cnt <= '0;
            n_words  <= '0;
        end else begin
            state    <= state_nx;
            core_rst <= (state_nx != RUN);
            if (state != IDLE) boot <= 1'b0;
            if (state != RELEASE && state_nx == RELEASE) begin
                hold_cnt <= HOLD_LD;
            end else if (state == RELEASE && hold_cnt != 4'd0) begin
                hold_cnt <= hold_cnt - 4'd1;
            end
            if (hdr_acc) begin
                n_words <= (rx_data == HDR_FULL) ? CAP_W
                                                 : (ADDR_W+1)'(rx_data);
            end
        end
    end

    // Address and count advance after each write, so the pulse sees the old address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_waddr   <= '0;
            words_loaded <= '0;
        end else if (hdr_acc) begin
            imem_waddr   <= '0;
            words_loaded <= '0;
        end else if (imem_we) begin
            imem_waddr   <= imem_waddr + A_ONE;
            words_loaded <= words_loaded + WL_ONE;
        end
    end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Self-checking bench for prog_load_ctrl: frame table plus scoreboard of
// expected memory writes, and hand-written reload and async-reset sequences.
module tb_prog_load_ctrl;

    localparam int RST_HOLD = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        load_req;
    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [15:0] imem_wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        err;
    logic [6:0]  words_loaded;

    int checks = 0;
    int errors = 0;
    logic [21:0] sb[$];

    typedef struct {
        logic [7:0]  hdr;
        logic [15:0] w0;
        logic [15:0] step;
        logic [7:0]  cflip;
        bit          gaps;
        bit          hold;
        bit          exp_done;
        bit          exp_err;
        int          exp_words;
    } vec_t;

    vec_t tbl[5];

    prog_load_ctrl #(
        .ADDR_W   (6),
        .RST_HOLD (RST_HOLD),
        .AUTOLOAD (0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .load_req     (load_req),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .core_rst     (core_rst),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL imem_write: got %0h:%0h want none",
                         imem_waddr, imem_wdata);
            end else begin
                chk("imem_write", {10'h0, imem_waddr, imem_wdata},
                    {10'h0, sb.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        if (gap) repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL accept: byte %0h rx_ready got 0 want 1", b);
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
            rx_data  = 8'hxx;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          nw;
        logic [7:0]  cs;
        logic [15:0] w;
        nw = (v.hdr == 8'h00) ? 64 : ((v.hdr > 8'd64) ? 0 : int'(v.hdr));
        @(negedge clk);
        load_req = 1'b1;
        @(posedge clk);
        #1;
        chk("start_busy", {31'h0, busy}, 1);
        chk("start_core_rst", {31'h0, core_rst}, 1);
        if (!v.hold) load_req = 1'b0;
        cs = v.hdr;
        send_byte(v.hdr, v.gaps);
        for (int i = 0; i < nw; i++) begin
            w = v.w0 + 16'(i) * v.step;
            sb.push_back({6'(i), w});
            send_byte(w[15:8], v.gaps);
            send_byte(w[7:0], v.gaps);
            cs = cs ^ w[15:8] ^ w[7:0];
        end
        load_req = 1'b0;
        if (nw != 0) begin
            send_byte(cs ^ v.cflip, v.gaps);
            if (v.exp_done) begin
                for (int k = 0; k < RST_HOLD; k++) begin
                    chk("hold_core_rst", {31'h0, core_rst}, 1);
                    chk("hold_rx_ready", {31'h0, rx_ready}, 0);
                    @(posedge clk);
                    #1;
                end
            end else begin
                repeat (3) @(posedge clk);
                #1;
            end
        end
        chk("end_done", {31'h0, done}, {31'h0, v.exp_done});
        chk("end_err", {31'h0, err}, {31'h0, v.exp_err});
        chk("end_core_rst", {31'h0, core_rst}, {31'h0, !v.exp_done});
        chk("end_rx_ready", {31'h0, rx_ready}, 0);
        chk("end_busy", {31'h0, busy}, 0);
        chk("words_loaded", {25'h0, words_loaded}, v.exp_words);
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_core_rst"}, {31'h0, core_rst}, 1);
        chk({tag, "_rx_ready"}, {31'h0, rx_ready}, 0);
        chk({tag, "_imem_we"}, {31'h0, imem_we}, 0);
        chk({tag, "_waddr"}, {26'h0, imem_waddr}, 0);
        chk({tag, "_wdata"}, {16'h0, imem_wdata}, 0);
        chk({tag, "_busy"}, {31'h0, busy}, 0);
        chk({tag, "_done"}, {31'h0, done}, 0);
        chk({tag, "_err"}, {31'h0, err}, 0);
        chk({tag, "_words"}, {25'h0, words_loaded}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        hdr    w0        step      cflip gap hold done err words
        tbl[0] = '{8'h02, 16'h1234, 16'h9999, 8'h00, 0, 0, 1, 0, 2};
        tbl[1] = '{8'h02, 16'h1234, 16'h9999, 8'h01, 0, 0, 0, 1, 2};
        tbl[2] = '{8'h00, 16'h0100, 16'h0203, 8'h00, 0, 0, 1, 0, 64};
        tbl[3] = '{8'h41, 16'h0000, 16'h0000, 8'h00, 0, 0, 0, 1, 0};
        tbl[4] = '{8'h03, 16'hBEEF, 16'h1111, 8'h00, 1, 1, 1, 0, 3};

        rst      = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        load_req = 1'b0;
        #12;
        chk_reset_vals("por");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", {31'h0, busy}, 0);
        chk("idle_rx_ready", {31'h0, rx_ready}, 0);
        chk("idle_core_rst", {31'h0, core_rst}, 1);

        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // Reload from RUN, then async reset in the middle of the frame.
        @(negedge clk);
        load_req = 1'b1;
        @(posedge clk);
        #1;
        chk("reload_core_rst", {31'h0, core_rst}, 1);
        chk("reload_busy", {31'h0, busy}, 1);
        load_req = 1'b0;
        send_byte(8'h05, 1'b0);
        sb.push_back({6'd0, 16'h5A5A});
        sb.push_back({6'd1, 16'hC3C3});
        send_byte(8'h5A, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'hC3, 1'b0);
        send_byte(8'hC3, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals("async");
        chk("async_sb", sb.size(), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", {31'h0, busy}, 0);

        run_vec(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
